// File: rtl/ysyx_23060208_isram_rsp.sv
// Instruction SRAM read responder: one outstanding AXI-lite style read with
// LFSR-driven or fixed response delay, plus a loader write port.
module ysyx_23060208_isram_rsp #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned           DEPTH_LOG2  = 12,
  parameter bit                    RAND_EN     = 1'b1,
  parameter int unsigned           DELAY_BITS  = 2,
  parameter int unsigned           FIXED_DELAY = 0,
  parameter logic [7:0]            LFSR_SEED   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] isram_araddr,
  input  logic                  isram_arvalid,
  output logic                  isram_arready,
  output logic [DATA_WIDTH-1:0] isram_rdata,
  output logic [1:0]            isram_rresp,
  output logic                  isram_rvalid,
  input  logic                  isram_rready,
  input  logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, DELAY, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DELAY_BITS-1:0]   cnt_q, cnt_d;
  logic [7:0]              lfsr_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    ar_hs;
  logic                    load_rsp;
  logic [DELAY_BITS-1:0]   delay_sel;
  logic [DATA_WIDTH-1:0]   rd_addr, rd_off;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic                    rd_in_range;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic [1:0]              rsp_code;
  logic [DATA_WIDTH-1:0]   wr_off;
  logic [DEPTH_LOG2-1:0]   wr_idx;
  logic                    wr_ok;

  assign ar_hs     = isram_arvalid && arready_q && (state_q == IDLE);
  assign delay_sel = RAND_EN ? lfsr_q[DELAY_BITS-1:0] : DELAY_BITS'(FIXED_DELAY);

  // With zero delay the response is registered on the handshake edge itself,
  // so decode must look at the live address rather than the captured one.
  assign rd_addr     = (state_q == IDLE) ? isram_araddr : addr_q;
  assign rd_off      = rd_addr - BASE_ADDR;
  assign rd_idx      = DEPTH_LOG2'(rd_off >> 2);
  assign rd_in_range = (rd_addr >= BASE_ADDR) && ((rd_off >> (DEPTH_LOG2 + 2)) == '0);

  always_comb begin
    rsp_data = '0;
    rsp_code = 2'b11;
    if (rd_in_range) begin
      if (rd_addr[1:0] != 2'b00) begin
        rsp_code = 2'b10;
      end else begin
        rsp_code = 2'b00;
        rsp_data = mem[rd_idx];
      end
    end
  end

  assign wr_off = mem_waddr - BASE_ADDR;
  assign wr_idx = DEPTH_LOG2'(wr_off >> 2);
  assign wr_ok  = (mem_waddr >= BASE_ADDR) && ((wr_off >> (DEPTH_LOG2 + 2)) == '0)
                  && (mem_waddr[1:0] == 2'b00);

  // Memory is deliberately not reset; a read sampled on the same edge sees old data.
  always_ff @(posedge clk) begin
    if (mem_we && wr_ok) begin
      mem[wr_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          state_d = (delay_sel == '0) ? RESP : DELAY;
        end
      end
      DELAY: begin
        if (cnt_q == DELAY_BITS'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rvalid_q && isram_rready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arready_d = (state_d == IDLE);
    rvalid_d  = (state_d == RESP);
    load_rsp  = (state_d == RESP) && (state_q != RESP);
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    if (ar_hs) begin
      cnt_d  = delay_sel;
      addr_d = isram_araddr;
    end else if (state_q == DELAY) begin
      cnt_d = cnt_q - DELAY_BITS'(1);
    end
    rdata_d = load_rsp ? rsp_data : rdata_q;
    rresp_d = load_rsp ? rsp_code : rresp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      addr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign isram_arready = arready_q;
  assign isram_rvalid  = rvalid_q;
  assign isram_rdata   = rdata_q;
  assign isram_rresp   = rresp_q;

endmodule

// File: tb/tb_ysyx_23060208_isram_rsp.sv
// Bench for ysyx_23060208_isram_rsp: three instances (fixed delay 0, fixed delay 3,
// random delay) checked against a word-array model of the memory map.
module tb_ysyx_23060208_isram_rsp;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SPAN = 32'h0000_4000;

  logic        clk;
  logic        rst;
  logic [31:0] araddr    [3];
  logic        arvalid   [3];
  logic        arready   [3];
  logic [31:0] rdata     [3];
  logic [1:0]  rresp     [3];
  logic        rvalid    [3];
  logic        rready    [3];
  logic        mem_we    [3];
  logic [31:0] mem_waddr [3];
  logic [31:0] mem_wdata [3];

  logic [31:0] mdl [3][4096];

  int total = 0;
  int bad   = 0;
  int rsp_cnt = 0;
  bit mon_en  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060208_isram_rsp #(.RAND_EN(1'b0), .FIXED_DELAY(0)) u_d0 (
    .clk(clk), .rst(rst),
    .isram_araddr(araddr[0]), .isram_arvalid(arvalid[0]), .isram_arready(arready[0]),
    .isram_rdata(rdata[0]), .isram_rresp(rresp[0]), .isram_rvalid(rvalid[0]),
    .isram_rready(rready[0]), .mem_we(mem_we[0]), .mem_waddr(mem_waddr[0]),
    .mem_wdata(mem_wdata[0]));

  ysyx_23060208_isram_rsp #(.RAND_EN(1'b0), .FIXED_DELAY(3)) u_d3 (
    .clk(clk), .rst(rst),
    .isram_araddr(araddr[1]), .isram_arvalid(arvalid[1]), .isram_arready(arready[1]),
    .isram_rdata(rdata[1]), .isram_rresp(rresp[1]), .isram_rvalid(rvalid[1]),
    .isram_rready(rready[1]), .mem_we(mem_we[1]), .mem_waddr(mem_waddr[1]),
    .mem_wdata(mem_wdata[1]));

  ysyx_23060208_isram_rsp #(.RAND_EN(1'b1)) u_rnd (
    .clk(clk), .rst(rst),
    .isram_araddr(araddr[2]), .isram_arvalid(arvalid[2]), .isram_arready(arready[2]),
    .isram_rdata(rdata[2]), .isram_rresp(rresp[2]), .isram_rvalid(rvalid[2]),
    .isram_rready(rready[2]), .mem_we(mem_we[2]), .mem_waddr(mem_waddr[2]),
    .mem_wdata(mem_wdata[2]));

  always @(posedge clk) begin
    if (mon_en && !rst && rvalid[2] === 1'b1 && rready[2] === 1'b1) rsp_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    if (a < BASE || a >= BASE + SPAN) return 2'b11;
    if (a % 4 != 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_data(input int i, input logic [31:0] a);
    if (exp_resp(a) != 2'b00) return 32'h0;
    return mdl[i][(a - BASE) / 4];
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
    mem_we[i] = 1'b1; mem_waddr[i] = a; mem_wdata[i] = d;
    @(negedge clk);
    mem_we[i] = 1'b0;
    if (exp_resp(a) == 2'b00) mdl[i][(a - BASE) / 4] = d;
  endtask

  // Issues one read at the current negedge and completes the R handshake with
  // rready asserted each cycle with probability pct percent.
  task automatic read_txn(input int i, input logic [31:0] a, input int pct,
                          output logic [31:0] d, output logic [1:0] r, output int lat,
                          output bit to, output bit acc, output bit hold_ok, output bit after_ok);
    bit done;
    int n;
    to = 0; hold_ok = 1; after_ok = 1; lat = 0; d = '0; r = '0;
    acc = (arready[i] === 1'b1);
    araddr[i] = a; arvalid[i] = 1'b1;
    @(negedge clk);
    arvalid[i] = 1'b0;
    lat = 1;
    while (rvalid[i] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (rvalid[i] !== 1'b1) begin
      to = 1;
      return;
    end
    d = rdata[i]; r = rresp[i];
    done = 0; n = 0;
    while (!done) begin
      if (rvalid[i] !== 1'b1 || rdata[i] !== d || rresp[i] !== r || arready[i] !== 1'b0)
        hold_ok = 0;
      rready[i] = (n >= 40) || ($urandom_range(99) < pct);
      done = rready[i];
      @(negedge clk);
      n++;
    end
    rready[i] = 1'b0;
    if (rvalid[i] !== 1'b0 || arready[i] !== 1'b1) after_ok = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total += 4;
      if (arready[i] !== 1'b0) begin bad++; $display("FAIL rst_arready[%0d]: got %b want 0", i, arready[i]); end
      if (rvalid[i] !== 1'b0) begin bad++; $display("FAIL rst_rvalid[%0d]: got %b want 0", i, rvalid[i]); end
      if (rresp[i] !== 2'b00) begin bad++; $display("FAIL rst_rresp[%0d]: got %b want 00", i, rresp[i]); end
      if (rdata[i] !== 32'h0) begin bad++; $display("FAIL rst_rdata[%0d]: got %h want 0", i, rdata[i]); end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (arready[i] !== 1'b1) begin bad++; $display("FAIL post_rst_arready[%0d]: got %b want 1", i, arready[i]); end
    end
  endtask

  task automatic test_fixed0();
    logic [31:0] d; logic [1:0] r; int lat; bit to, acc, hok, aok;
    load(0, BASE, 32'h0000_0413);
    read_txn(0, BASE, 100, d, r, lat, to, acc, hok, aok);
    total += 6;
    if (to !== 1'b0) begin bad++; $display("FAIL f0_timeout: got %b want 0", to); end
    if (acc !== 1'b1) begin bad++; $display("FAIL f0_accept: got %b want 1", acc); end
    if (lat != 1) begin bad++; $display("FAIL f0_latency: got %0d want 1", lat); end
    if (d !== 32'h0000_0413) begin bad++; $display("FAIL f0_rdata: got %h want 00000413", d); end
    if (r !== 2'b00) begin bad++; $display("FAIL f0_rresp: got %b want 00", r); end
    if (aok !== 1'b1) begin bad++; $display("FAIL f0_after: got %b want 1", aok); end
  endtask

  task automatic test_fixed3();
    logic [31:0] a, v;
    a = BASE + 32'h40;
    v = $urandom;
    load(1, a, v);
    total++;
    if (arready[1] !== 1'b1) begin bad++; $display("FAIL f3_arready_idle: got %b want 1", arready[1]); end
    araddr[1] = a; arvalid[1] = 1'b1;
    @(negedge clk);
    arvalid[1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      total += 2;
      if (rvalid[1] !== 1'b0) begin bad++; $display("FAIL f3_early_rvalid@%0d: got %b want 0", k, rvalid[1]); end
      if (arready[1] !== 1'b0) begin bad++; $display("FAIL f3_delay_arready@%0d: got %b want 0", k, arready[1]); end
      @(negedge clk);
    end
    for (int k = 0; k < 6; k++) begin
      total += 4;
      if (rvalid[1] !== 1'b1) begin bad++; $display("FAIL f3_rvalid@%0d: got %b want 1", k, rvalid[1]); end
      if (rdata[1] !== v) begin bad++; $display("FAIL f3_rdata@%0d: got %h want %h", k, rdata[1], v); end
      if (rresp[1] !== 2'b00) begin bad++; $display("FAIL f3_rresp@%0d: got %b want 00", k, rresp[1]); end
      if (arready[1] !== 1'b0) begin bad++; $display("FAIL f3_hold_arready@%0d: got %b want 0", k, arready[1]); end
      // Stray requests while busy must be ignored.
      araddr[1] = BASE + 32'h80 + 4 * k;
      arvalid[1] = (k < 5);
      rready[1] = (k == 5);
      @(negedge clk);
    end
    rready[1] = 1'b0;
    arvalid[1] = 1'b0;
    total += 2;
    if (rvalid[1] !== 1'b0) begin bad++; $display("FAIL f3_after_rvalid: got %b want 0", rvalid[1]); end
    if (arready[1] !== 1'b1) begin bad++; $display("FAIL f3_after_arready: got %b want 1", arready[1]); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (rvalid[1] !== 1'b0) begin bad++; $display("FAIL f3_not_queued@%0d: got %b want 0", k, rvalid[1]); end
    end
  endtask

  task automatic test_decode();
    logic [31:0] tbl [7];
    logic [31:0] d; logic [1:0] r; int lat; bit to, acc, hok, aok;
    load(0, BASE + SPAN - 4, $urandom);
    load(0, BASE + SPAN, 32'h1111_1111);
    load(0, BASE + 32'h1, 32'h2222_2222);
    load(0, BASE - 4, 32'h3333_3333);
    tbl = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_4000, 32'h8000_0000,
            32'h8000_3FFC, 32'h8000_0003, 32'hFFFF_FFFC};
    foreach (tbl[k]) begin
      read_txn(0, tbl[k], 100, d, r, lat, to, acc, hok, aok);
      total += 3;
      if (to !== 1'b0) begin bad++; $display("FAIL dec_timeout %h: got %b want 0", tbl[k], to); end
      if (r !== exp_resp(tbl[k])) begin bad++; $display("FAIL dec_rresp %h: got %b want %b", tbl[k], r, exp_resp(tbl[k])); end
      if (d !== exp_data(0, tbl[k])) begin bad++; $display("FAIL dec_rdata %h: got %h want %h", tbl[k], d, exp_data(0, tbl[k])); end
    end
  endtask

  task automatic test_rbw();
    logic [31:0] a, old;
    logic [31:0] d; logic [1:0] r; int lat; bit to, acc, hok, aok;
    a = BASE + 32'h100;
    load(0, a, 32'h1234_5678);
    old = exp_data(0, a);
    araddr[0] = a; arvalid[0] = 1'b1; rready[0] = 1'b1;
    mem_we[0] = 1'b1; mem_waddr[0] = a; mem_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    arvalid[0] = 1'b0; mem_we[0] = 1'b0;
    mdl[0][(a - BASE) / 4] = 32'hDEAD_BEEF;
    total += 2;
    if (rvalid[0] !== 1'b1) begin bad++; $display("FAIL rbw0_rvalid: got %b want 1", rvalid[0]); end
    if (rdata[0] !== old) begin bad++; $display("FAIL rbw0_old: got %h want %h", rdata[0], old); end
    @(negedge clk);
    rready[0] = 1'b0;
    read_txn(0, a, 100, d, r, lat, to, acc, hok, aok);
    total++;
    if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rbw0_new: got %h want deadbeef", d); end

    a = BASE + 32'h200;
    load(1, a, 32'hCAFE_0001);
    old = exp_data(1, a);
    araddr[1] = a; arvalid[1] = 1'b1;
    @(negedge clk);
    arvalid[1] = 1'b0;
    repeat (2) @(negedge clk);
    mem_we[1] = 1'b1; mem_waddr[1] = a; mem_wdata[1] = 32'hDEAD_BEEF; rready[1] = 1'b1;
    @(negedge clk);
    mem_we[1] = 1'b0;
    mdl[1][(a - BASE) / 4] = 32'hDEAD_BEEF;
    total += 2;
    if (rvalid[1] !== 1'b1) begin bad++; $display("FAIL rbw3_rvalid: got %b want 1", rvalid[1]); end
    if (rdata[1] !== old) begin bad++; $display("FAIL rbw3_old: got %h want %h", rdata[1], old); end
    @(negedge clk);
    rready[1] = 1'b0;
    read_txn(1, a, 100, d, r, lat, to, acc, hok, aok);
    total += 2;
    if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rbw3_new: got %h want deadbeef", d); end
    if (lat != 4) begin bad++; $display("FAIL rbw3_latency: got %0d want 4", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, v;
    logic [31:0] d; logic [1:0] r; int lat; bit to, acc, hok, aok;
    a = BASE + 32'h300;
    v = $urandom;
    load(1, a, v);
    araddr[1] = a; arvalid[1] = 1'b1;
    @(negedge clk);
    arvalid[1] = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++;
    if (rvalid[1] !== 1'b0) begin bad++; $display("FAIL rmid_rvalid_in_rst: got %b want 0", rvalid[1]); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (arready[1] !== 1'b1) begin bad++; $display("FAIL rmid_arready: got %b want 1", arready[1]); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rvalid[1] !== 1'b0) begin bad++; $display("FAIL rmid_no_rsp@%0d: got %b want 0", k, rvalid[1]); end
      @(negedge clk);
    end
    read_txn(1, a, 100, d, r, lat, to, acc, hok, aok);
    total += 2;
    if (d !== v) begin bad++; $display("FAIL rmid_data: got %h want %h", d, v); end
    if (lat != 4) begin bad++; $display("FAIL rmid_latency: got %0d want 4", lat); end

    araddr[1] = a; arvalid[1] = 1'b1;
    @(negedge clk);
    arvalid[1] = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (rvalid[1] !== 1'b1) begin bad++; $display("FAIL rresp_abort_pre: got %b want 1", rvalid[1]); end
    rst = 1'b1;
    @(negedge clk);
    total += 3;
    if (rvalid[1] !== 1'b0) begin bad++; $display("FAIL rresp_abort_rvalid: got %b want 0", rvalid[1]); end
    if (rdata[1] !== 32'h0) begin bad++; $display("FAIL rresp_abort_rdata: got %h want 0", rdata[1]); end
    if (rresp[1] !== 2'b00) begin bad++; $display("FAIL rresp_abort_rresp: got %b want 00", rresp[1]); end
    rst = 1'b0;
    @(negedge clk);
    total += 2;
    if (arready[1] !== 1'b1) begin bad++; $display("FAIL rresp_abort_arready: got %b want 1", arready[1]); end
    if (rvalid[1] !== 1'b0) begin bad++; $display("FAIL rresp_abort_after: got %b want 0", rvalid[1]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] la [64];
    logic [31:0] a, d; logic [1:0] r; int lat; bit to, acc, hok, aok;
    bit seen [5];
    int acc_cnt, sel;
    for (int k = 0; k < 64; k++) begin
      la[k] = BASE + 4 * $urandom_range(0, 4095);
      load(2, la[k], $urandom);
    end
    foreach (seen[k]) seen[k] = 0;
    acc_cnt = 0;
    rsp_cnt = 0;
    mon_en = 1;
    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 90) a = la[$urandom_range(0, 63)];
      else if (sel < 95) a = la[$urandom_range(0, 63)] + $urandom_range(1, 3);
      else if (sel < 98) a = BASE - 4 * $urandom_range(1, 1000);
      else a = BASE + SPAN + 4 * $urandom_range(0, 1000);
      read_txn(2, a, 50, d, r, lat, to, acc, hok, aok);
      if (acc) acc_cnt++;
      total += 6;
      if (to !== 1'b0) begin bad++; $display("FAIL b2b_timeout #%0d: got %b want 0", n, to); end
      if (acc !== 1'b1) begin bad++; $display("FAIL b2b_accept #%0d: got %b want 1", n, acc); end
      if (lat < 1 || lat > 4) begin bad++; $display("FAIL b2b_latency #%0d: got %0d want 1..4", n, lat); end
      else seen[lat] = 1;
      if (r !== exp_resp(a)) begin bad++; $display("FAIL b2b_rresp #%0d %h: got %b want %b", n, a, r, exp_resp(a)); end
      if (d !== exp_data(2, a)) begin bad++; $display("FAIL b2b_rdata #%0d %h: got %h want %h", n, a, d, exp_data(2, a)); end
      if ((hok & aok) !== 1'b1) begin bad++; $display("FAIL b2b_protocol #%0d: hold=%b after=%b want 1/1", n, hok, aok); end
    end
    repeat (6) @(negedge clk);
    mon_en = 0;
    total += 2;
    if (rsp_cnt != acc_cnt) begin bad++; $display("FAIL b2b_rsp_count: got %0d want %0d", rsp_cnt, acc_cnt); end
    if (acc_cnt != 1000) begin bad++; $display("FAIL b2b_accept_count: got %0d want 1000", acc_cnt); end
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (seen[k] !== 1'b1) begin bad++; $display("FAIL b2b_cover_lat%0d: got %b want 1", k, seen[k]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      araddr[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
      mem_we[i] = 1'b0; mem_waddr[i] = '0; mem_wdata[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_fixed0();
    test_fixed3();
    test_decode();
    test_rbw();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
